data_check: RTL and testbench
=============================

Name: data_check

Overview:
Receive-side checker for the 8-bit self-incrementing stream produced by the team's data generator (0,1,…,31,0,…).
- Acquires lock on the sequence and then tracks it.
- Flags and counts sequence errors, and drops lock after repeated errors.
- Sits at the sink end of the loopback/simulation path to qualify the generator→DUT→sink data path.

Parameters:
DATA_W, 8, data word width
MAX_VAL, 31, last value before wrap to 0; must match the generator
LOCK_CNT, 4, consecutive correct samples needed to declare lock (≥2)
LOSS_CNT, 3, consecutive mismatches in lock needed to drop lock (≥1)
CNT_W, 16, width of error and good-sample counters

Ports:
clk  in  1  sampling clock, rising edge
rst  in  1  asynchronous active-low reset
data_in  in  DATA_W  received sample
data_valid  in  1  data_in is a sample this cycle
clr  in  1  synchronous clear of err_cnt and good_cnt; does not affect lock state
locked  out  1  sequence lock indicator
err_pulse  out  1  one-cycle strobe on each counted mismatch
err_cnt  out  CNT_W  saturating mismatch count
good_cnt  out  CNT_W  saturating count of matched samples while locked
expected  out  DATA_W  next value the checker expects

Behaviour:
- Reset (rst=0, asynchronous): state=HUNT; locked=0, err_pulse=0, err_cnt=0, good_cnt=0, expected=0; internal run counters=0.
- All outputs are registered. Response to a sample appears the cycle after the clk edge at which data_valid=1. With data_valid=0, everything holds except err_pulse, which is forced to 0.
- next(v) = (v >= MAX_VAL) ? 0 : v+1. Computed at DATA_W width; no overflow beyond that width.
- match = (data_in == expected).
- FSM states: HUNT, SYNC, LOCKED, LOSING. Transitions below apply only on valid samples.
- HUNT:
  - data_in ≤ MAX_VAL: expected<=next(data_in), good_run<=1, go to SYNC.
  - data_in > MAX_VAL: stay in HUNT.
- SYNC:
  - match: good_run++; expected<=next(expected). When good_run+1 == LOCK_CNT, go to LOCKED with locked<=1.
  - mismatch: reseed as in HUNT (stay SYNC with good_run=1), or go to HUNT if data_in > MAX_VAL.
  - No errors are counted in HUNT or SYNC.
- LOCKED:
  - match: good_cnt++ (saturating).
  - mismatch: err_pulse<=1, err_cnt++ (saturating), bad_run<=1, go to LOSING. If LOSS_CNT==1, go directly to HUNT instead.
  - In both cases expected<=next(expected). This is a flywheel: expected keeps advancing and is never reseeded from bad data.
- LOSING:
  - match: bad_run<=0, good_cnt++, back to LOCKED.
  - mismatch: err_pulse, err_cnt++, bad_run++. When bad_run+1 == LOSS_CNT, go to HUNT with locked<=0.
  - expected<=next(expected) always. locked stays 1 while in LOSING.
- Saturation: err_cnt and good_cnt stop at 2^CNT_W−1; they do not wrap.
- clr and a counted event in the same cycle: clr wins, so the counter becomes 0. err_pulse still fires.
- Wrap boundary: expected=MAX_VAL with data_in=MAX_VAL is a match, and expected becomes 0.
- Reset mid-operation: immediate return to the reset values; the lock must be reacquired.
- Required RTL style: 2-process FSM plus datapath; run counters sized $clog2(max(LOCK_CNT,LOSS_CNT)+1).

Decomposition:
- Shared package:
  - state enum (HUNT/SYNC/LOCKED/LOSING)
  - MAX_VAL default constant, shared with the generator so both ends agree on the wrap point
  - next-value function next(v)
- One natural sub-module: sat_counter (CNT_W, inc, clr → cnt), instantiated twice for err_cnt and good_cnt.

Test Plan:
1. Reset, then generator stream 0,1,2,… with valid every cycle → locked=1 one cycle after the 4th sample (value 3); err_cnt=0; good_cnt increments thereafter.
2. Locked stream across the wrap …30,31,0,1 → no err_pulse; expected shows 0 after the 31 sample.
3. Locked, inject a single 7 in place of 12, then resume 13,14 → one err_pulse, err_cnt=1, locked stays 1, state returns to LOCKED on 13.
4. Locked, inject 3 consecutive wrong values (e.g. 0xFF ×3) → err_cnt=3; locked=0 after the third; next valid 5,6,7,8 relocks after 8.
5. Gapped valid (valid every other cycle) on a correct stream → same lock timing counted in samples; outputs hold and err_pulse=0 on idle cycles.
6. With err_cnt=5, assert clr together with a mismatch → err_cnt=0 and err_pulse=1. Separately, assert rst=0 asynchronously mid-stream → outputs clear immediately without waiting for clk, and lock is reacquired after 4 samples.

Source files
------------

// File: rtl/data_check_pkg.sv
// data_check_pkg: definitions shared by the sequence checker and the data
// generator, so that both ends agree on the wrap point and on the successor
// rule.
//   state_t     : checker FSM states.
//   MAX_VAL_DEF : last value before the stream wraps to 0.
//   next_val()  : successor of v in the stream (0 after max_v).
package data_check_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2,
    LOSING = 2'd3
  } state_t;

  localparam int MAX_VAL_DEF = 31;

  // Evaluated at 32 bits. Callers truncate the result to their own word width.
  function automatic logic [31:0] next_val(input logic [31:0] v,
                                           input logic [31:0] max_v);
    return (v >= max_v) ? 32'd0 : v + 32'd1;
  endfunction

endpackage

// File: rtl/data_check_sat_counter.sv
// data_check_sat_counter: an up-counter that saturates at all-ones and has a
// synchronous clear. When clr and inc are both high, clr wins.
//   clk, rst : clock, and asynchronous active-low reset
//   inc      : count one event
//   clr      : synchronous clear to 0
//   cnt      : current count
module data_check_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  cnt <= '0;
    else if (clr)              cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/data_check.sv
// data_check: receive-side checker for the self-incrementing generator
// stream (0, 1, ..., MAX_VAL, 0, ...). It first acquires lock on the stream,
// then tracks it with a flywheel: the expected value keeps advancing and is
// never reseeded from bad data. It counts mismatches, and it drops lock after
// LOSS_CNT consecutive mismatches.
//   clk, rst   : clock, and asynchronous active-low reset
//   data_in    : received sample; data_valid marks a sample cycle
//   clr        : synchronous clear of err_cnt and good_cnt (lock state kept)
//   locked     : sequence lock indicator
//   err_pulse  : one-cycle strobe on each counted mismatch
//   err_cnt    : saturating mismatch count
//   good_cnt   : saturating count of matched samples while locked
//   expected   : next value the checker expects
// Every output is registered. A sample's effect shows on the cycle after the
// sample is taken.
module data_check
  import data_check_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int MAX_VAL  = MAX_VAL_DEF,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  input  logic              clr,
  output logic              locked,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  good_cnt,
  output logic [DATA_W-1:0] expected
);

  localparam int RUN_MAX = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);

  localparam logic [DATA_W-1:0] MAXV   = DATA_W'(MAX_VAL);
  localparam logic [RUN_W-1:0]  LOCK_N = RUN_W'(LOCK_CNT);
  localparam logic [RUN_W-1:0]  LOSS_N = RUN_W'(LOSS_CNT);

  function automatic logic [DATA_W-1:0] nxt(input logic [DATA_W-1:0] v);
    return DATA_W'(next_val(32'(v), 32'(MAX_VAL)));
  endfunction

  state_t            st, st_n;
  logic [DATA_W-1:0] exp_n;
  logic [RUN_W-1:0]  good_run, good_run_n;
  logic [RUN_W-1:0]  bad_run, bad_run_n;
  logic              locked_n, errp_n;
  logic              err_inc, good_inc;
  logic              match, in_range;

  assign match    = (data_in == expected);
  assign in_range = (data_in <= MAXV);

  // Next-state and datapath logic. Only a valid sample moves the FSM.
  always_comb begin
    st_n       = st;
    exp_n      = expected;
    good_run_n = good_run;
    bad_run_n  = bad_run;
    locked_n   = locked;
    errp_n     = 1'b0;
    err_inc    = 1'b0;
    good_inc   = 1'b0;
    if (data_valid) begin
      case (st)
        HUNT: begin
          if (in_range) begin
            exp_n      = nxt(data_in);
            good_run_n = RUN_W'(1);
            st_n       = SYNC;
          end
        end
        SYNC: begin
          if (match) begin
            good_run_n = good_run + 1'b1;
            exp_n      = nxt(expected);
            if (good_run + 1'b1 == LOCK_N) begin
              st_n     = LOCKED;
              locked_n = 1'b1;
            end
          end else if (in_range) begin
            // Reseed from this sample; it counts as the first good sample of a new run.
            exp_n      = nxt(data_in);
            good_run_n = RUN_W'(1);
          end else begin
            good_run_n = '0;
            st_n       = HUNT;
          end
        end
        LOCKED: begin
          exp_n = nxt(expected);
          if (match) begin
            good_inc = 1'b1;
          end else begin
            errp_n    = 1'b1;
            err_inc   = 1'b1;
            bad_run_n = RUN_W'(1);
            if (LOSS_CNT == 1) begin
              st_n     = HUNT;
              locked_n = 1'b0;
            end else begin
              st_n = LOSING;
            end
          end
        end
        LOSING: begin
          exp_n = nxt(expected);
          if (match) begin
            bad_run_n = '0;
            good_inc  = 1'b1;
            st_n      = LOCKED;
          end else begin
            errp_n    = 1'b1;
            err_inc   = 1'b1;
            bad_run_n = bad_run + 1'b1;
            if (bad_run + 1'b1 == LOSS_N) begin
              st_n     = HUNT;
              locked_n = 1'b0;
            end
          end
        end
        default: st_n = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= HUNT;
      expected  <= '0;
      good_run  <= '0;
      bad_run   <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      st        <= st_n;
      expected  <= exp_n;
      good_run  <= good_run_n;
      bad_run   <= bad_run_n;
      locked    <= locked_n;
      err_pulse <= errp_n;
    end
  end

  data_check_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk(clk), .rst(rst), .inc(err_inc), .clr(clr), .cnt(err_cnt)
  );

  data_check_sat_counter #(.CNT_W(CNT_W)) u_good_cnt (
    .clk(clk), .rst(rst), .inc(good_inc), .clr(clr), .cnt(good_cnt)
  );

endmodule

// File: tb/tb_data_check.sv
module tb_data_check;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  data_in = '0;
  logic        data_valid = 1'b0;
  logic        clr = 1'b0;
  logic        locked, err_pulse;
  logic [15:0] err_cnt, good_cnt;
  logic [7:0]  expected;

  // Second instance: narrow counters for saturation, and single-miss loss of lock.
  logic        rst2 = 1'b0;
  logic [7:0]  d2 = '0;
  logic        v2 = 1'b0;
  logic        clr2 = 1'b0;
  logic        lk2, ep2;
  logic [2:0]  ec2, gc2;
  logic [7:0]  ex2;

  always #5 clk = ~clk;

  data_check dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid), .clr(clr),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .good_cnt(good_cnt),
    .expected(expected)
  );

  data_check #(.DATA_W(8), .MAX_VAL(31), .LOCK_CNT(4), .LOSS_CNT(1), .CNT_W(3)) dut2 (
    .clk(clk), .rst(rst2), .data_in(d2), .data_valid(v2), .clr(clr2),
    .locked(lk2), .err_pulse(ep2), .err_cnt(ec2), .good_cnt(gc2), .expected(ex2)
  );

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        c;
    logic        lk;
    logic        ep;
    logic [15:0] ec;
    logic [15:0] gc;
    logic [7:0]  ex;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h want %0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic c, input logic lk,
                     input logic ep, input int ec, input int gc, input int ex);
    vec_t r;
    r.v = v; r.d = d; r.c = c; r.lk = lk; r.ep = ep;
    r.ec = 16'(ec); r.gc = 16'(gc); r.ex = 8'(ex);
    tbl.push_back(r);
  endtask

  task automatic run_table(input int base);
    foreach (tbl[i]) begin
      @(negedge clk);
      data_valid = tbl[i].v; data_in = tbl[i].d; clr = tbl[i].c;
      @(posedge clk); #1;
      chk("locked",    base + i, 32'(locked),    32'(tbl[i].lk));
      chk("err_pulse", base + i, 32'(err_pulse), 32'(tbl[i].ep));
      chk("err_cnt",   base + i, 32'(err_cnt),   32'(tbl[i].ec));
      chk("good_cnt",  base + i, 32'(good_cnt),  32'(tbl[i].gc));
      chk("expected",  base + i, 32'(expected),  32'(tbl[i].ex));
    end
    @(negedge clk);
    data_valid = 1'b0; clr = 1'b0;
    tbl.delete();
  endtask

  task automatic step2(input logic [7:0] d);
    @(negedge clk);
    v2 = 1'b1; d2 = d;
    @(posedge clk); #1;
    @(negedge clk);
    v2 = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_locked", 0, 32'(locked), 0);
    chk("rst_errp",   0, 32'(err_pulse), 0);
    chk("rst_errcnt", 0, 32'(err_cnt), 0);
    chk("rst_good",   0, 32'(good_cnt), 0);
    chk("rst_exp",    0, 32'(expected), 0);
    @(negedge clk); rst = 1'b1; rst2 = 1'b1;

    // Acquisition: lock one cycle after the sample 3.
    add(1, 0, 0, 0, 0, 0, 0, 1);
    add(1, 1, 0, 0, 0, 0, 0, 2);
    add(1, 2, 0, 0, 0, 0, 0, 3);
    add(1, 3, 0, 1, 0, 0, 0, 4);
    for (int k = 4; k <= 11; k++) add(1, 8'(k), 0, 1, 0, 0, k - 3, k + 1);
    // A single bad sample (7 where 12 is expected), then the stream resumes.
    add(1, 7, 0, 1, 1, 1, 8, 13);
    add(1, 13, 0, 1, 0, 1, 9, 14);
    add(1, 14, 0, 1, 0, 1, 10, 15);
    // Across the wrap.
    for (int k = 15; k <= 31; k++) add(1, 8'(k), 0, 1, 0, 1, k - 4, (k == 31) ? 0 : k + 1);
    add(1, 0, 0, 1, 0, 1, 28, 1);
    add(1, 1, 0, 1, 0, 1, 29, 2);
    // Three misses drop lock. The idle cycle holds state and forces err_pulse low.
    add(1, 8'hFF, 0, 1, 1, 2, 29, 3);
    add(0, 8'hFF, 0, 1, 0, 2, 29, 3);
    add(1, 8'hFF, 0, 1, 1, 3, 29, 4);
    add(1, 8'hFF, 0, 0, 1, 4, 29, 5);
    // Relock on 5,6,7,8.
    add(1, 5, 0, 0, 0, 4, 29, 6);
    add(1, 6, 0, 0, 0, 4, 29, 7);
    add(1, 7, 0, 0, 0, 4, 29, 8);
    add(1, 8, 0, 1, 0, 4, 29, 9);
    add(1, 9, 0, 1, 0, 4, 30, 10);
    add(1, 8'hAA, 0, 1, 1, 5, 30, 11);
    // clr together with a counted miss: counters clear, err_pulse still fires.
    add(1, 8'hAA, 1, 1, 1, 0, 0, 12);
    add(1, 12, 0, 1, 0, 0, 1, 13);
    run_table(0);

    // Asynchronous reset away from any clock edge.
    @(posedge clk); #1;
    rst = 1'b0;
    #2;
    chk("arst_locked", 0, 32'(locked), 0);
    chk("arst_errp",   0, 32'(err_pulse), 0);
    chk("arst_good",   0, 32'(good_cnt), 0);
    chk("arst_exp",    0, 32'(expected), 0);
    @(negedge clk); rst = 1'b1;

    // Edge cases while hunting, then a gapped stream.
    add(1, 40, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 1);
    add(1, 5, 0, 0, 0, 0, 0, 6);
    add(1, 50, 0, 0, 0, 0, 0, 6);
    add(1, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 1, 0, 0, 0, 0, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0, 2);
    add(1, 2, 0, 0, 0, 0, 0, 3);
    add(0, 0, 0, 0, 0, 0, 0, 3);
    add(1, 3, 0, 1, 0, 0, 0, 4);
    add(0, 0, 0, 1, 0, 0, 0, 4);
    add(1, 4, 0, 1, 0, 0, 1, 5);
    add(1, 9, 0, 1, 1, 1, 1, 6);
    add(0, 9, 0, 1, 0, 1, 1, 6);
    add(1, 6, 0, 1, 0, 1, 2, 7);
    run_table(100);

    // Saturation of the 3-bit counters, and loss of lock on a single miss.
    for (int k = 0; k <= 13; k++) step2(8'(k));
    chk("sat_good", 0, 32'(gc2), 7);
    chk("lk2_on",   0, 32'(lk2), 1);
    @(negedge clk); v2 = 1'b1; d2 = 8'hFF;
    @(posedge clk); #1;
    chk("l1_errp",  0, 32'(ep2), 1);
    chk("l1_lock",  0, 32'(lk2), 0);
    chk("l1_err",   0, 32'(ec2), 1);
    chk("l1_exp",   0, 32'(ex2), 15);
    @(negedge clk); v2 = 1'b0;
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k <= 3; k++) step2(8'(k));
      step2(8'hFF);
    end
    chk("sat_err",  0, 32'(ec2), 7);
    chk("sat_lock", 0, 32'(lk2), 0);
    chk("sat_good2", 0, 32'(gc2), 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
